// File: rtl/note_tone_gen.sv
// Multi-channel square-wave tone generator: note/octave requests are turned
// into half-periods by a table lookup and a bit-serial restoring divider.
`timescale 1ns/1ps
module note_tone_gen #(
  parameter  int CLK_FREQ = 50000000,
  parameter  int CHANNELS = 2,
  parameter  int DIV_W    = 22,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DVD_W    = $clog2(CLK_FREQ * 8 + 1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CH_W-1:0]     req_chan,
  input  logic [3:0]          req_note,
  input  logic [3:0]          req_octave,
  input  logic                req_off,
  output logic                done,
  output logic                done_err,
  output logic [DIV_W-1:0]    done_period,
  output logic [CHANNELS-1:0] tone_out
);

  localparam int CNT_W = $clog2(DVD_W);
  localparam int QW    = (DVD_W > DIV_W) ? DVD_W : DIV_W;

  localparam logic [DVD_W-1:0] DIVIDEND = DVD_W'(CLK_FREQ * 8);
  localparam logic [QW-1:0]    PER_MAX  =
    QW'((65'd1 << DIV_W) - 65'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_DIVIDE,
    S_WRITE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CH_W-1:0]  chan_q;
  logic [3:0]       note_q;
  logic [3:0]       oct_q;
  logic             off_q;

  logic             err_q;
  logic             zero_q;
  logic             wr_ok_q;

  logic [16:0]      dvs_q;
  logic [16:0]      rem_q;
  logic [DVD_W-1:0] quo_q;
  logic [CNT_W-1:0] bit_q;

  logic             ready_q;
  logic             done_q;
  logic             done_err_q;
  logic [DIV_W-1:0] done_per_q;

  logic [DIV_W-1:0]    half_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] tone_q;

  logic [16:0] lk_base;
  logic [16:0] lk_freq;
  logic [3:0]  lk_top;
  logic [3:0]  lk_lo;
  logic [3:0]  lk_shift;
  logic        lk_oct_ok;
  logic        lk_chan_ok;
  logic        lk_err;
  logic        lk_zero;

  logic [17:0] dv_trial;
  logic [16:0] dv_diff;
  logic        dv_ge;
  logic [16:0] dv_rem;

  logic [QW-1:0]       quo_ext;
  logic [DIV_W-1:0]    wr_val;
  logic [CHANNELS-1:0] wr_sel;
  logic                accept;

  assign accept = req_valid && ready_q;

  // Octave-top frequencies in Hz x16; C tops out one octave higher.
  always_comb begin
    lk_base = '0;
    case (note_q)
      4'd0:    lk_base = 17'd56320;
      4'd1:    lk_base = 17'd59669;
      4'd2:    lk_base = 17'd63217;
      4'd3:    lk_base = 17'd66976;
      4'd4:    lk_base = 17'd35479;
      4'd5:    lk_base = 17'd37589;
      4'd6:    lk_base = 17'd39824;
      4'd7:    lk_base = 17'd42192;
      4'd8:    lk_base = 17'd44701;
      4'd9:    lk_base = 17'd47359;
      4'd10:   lk_base = 17'd50175;
      4'd11:   lk_base = 17'd53159;
      default: lk_base = '0;
    endcase
    lk_top     = (note_q == 4'd3) ? 4'd8 : 4'd7;
    lk_lo      = (note_q < 4'd3) ? 4'd0 : 4'd1;
    lk_oct_ok  = (note_q < 4'd12)
              && (oct_q >= lk_lo)
              && (oct_q <= lk_top);
    lk_shift   = lk_top - oct_q;
    lk_freq    = lk_base >> lk_shift;
    lk_chan_ok = int'(chan_q) < CHANNELS;
    lk_err     = !lk_chan_ok || (!off_q && !lk_oct_ok);
    lk_zero    = lk_err || off_q;
  end

  always_comb begin
    dv_trial = {rem_q, quo_q[DVD_W-1]};
    dv_ge    = dv_trial >= {1'b0, dvs_q};
    dv_diff  = dv_trial[16:0] - dvs_q;
    dv_rem   = dv_ge ? dv_diff : dv_trial[16:0];
  end

  always_comb begin
    quo_ext = QW'(quo_q);
    wr_val  = '0;
    if (!zero_q) begin
      if (quo_ext > PER_MAX) wr_val = '1;
      else                   wr_val = quo_ext[DIV_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = lk_zero ? S_WRITE : S_DIVIDE;
      S_DIVIDE: begin
        if (bit_q == CNT_W'(DVD_W - 1)) state_d = S_WRITE;
      end
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      chan_q     <= '0;
      note_q     <= '0;
      oct_q      <= '0;
      off_q      <= 1'b0;
      err_q      <= 1'b0;
      zero_q     <= 1'b0;
      wr_ok_q    <= 1'b0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_per_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Ready returns one cycle after the done pulse.
          if (done_q) ready_q <= 1'b1;
          if (accept) begin
            chan_q  <= req_chan;
            note_q  <= req_note;
            oct_q   <= req_octave;
            off_q   <= req_off;
            ready_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          err_q   <= lk_err;
          zero_q  <= lk_zero;
          wr_ok_q <= lk_chan_ok;
          dvs_q   <= lk_freq;
          rem_q   <= '0;
          quo_q   <= DIVIDEND;
          bit_q   <= '0;
        end
        S_DIVIDE: begin
          rem_q <= dv_rem;
          quo_q <= {quo_q[DVD_W-2:0], dv_ge};
          bit_q <= bit_q + CNT_W'(1);
        end
        S_WRITE: begin
          done_q     <= 1'b1;
          done_err_q <= err_q;
          done_per_q <= wr_val;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = (state_q == S_WRITE)
               && wr_ok_q
               && (chan_q == CH_W'(i));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        half_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      tone_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_sel[i]) begin
          half_q[i] <= wr_val;
          cnt_q[i]  <= '0;
          tone_q[i] <= 1'b0;
        end else if (half_q[i] == '0) begin
          cnt_q[i]  <= '0;
          tone_q[i] <= 1'b0;
        end else if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
          cnt_q[i]  <= '0;
          tone_q[i] <= ~tone_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  assign req_ready   = ready_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign done_period = done_per_q;
  assign tone_out    = tone_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed table, random requests against a
// frequency-level model, and waveform checks on every channel each cycle.
`timescale 1ns/1ps
module tb_note_tone_gen;

  localparam int     CLK_FREQ = 50000000;
  localparam int     NCH      = 3;
  localparam int     DIV_W    = 22;
  localparam int     CH_W     = 2;
  localparam int     DVD_W    = 29;
  localparam longint PMAX     = (64'd1 << DIV_W) - 1;
  localparam int     NV       = 18;

  logic             clock;
  logic             resetn;
  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_chan;
  logic [3:0]       req_note;
  logic [3:0]       req_octave;
  logic             req_off;
  logic             done;
  logic             done_err;
  logic [DIV_W-1:0] done_period;
  logic [NCH-1:0]   tone_out;

  note_tone_gen #(
    .CLK_FREQ(CLK_FREQ),
    .CHANNELS(NCH),
    .DIV_W(DIV_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_chan(req_chan),
    .req_note(req_note),
    .req_octave(req_octave),
    .req_off(req_off),
    .done(done),
    .done_err(done_err),
    .done_period(done_period),
    .tone_out(tone_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int     ch;
    int     err;
    longint per;
    int     lat;
    bit     wr;
    longint acc;
  } exp_t;

  typedef struct {
    int     ch;
    int     nt;
    int     oc;
    bit     off;
    int     err;
    longint per;
    int     lat;
  } vec_t;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  int     acc_cnt = 0;
  int     done_cnt = 0;
  int     last_err;
  longint last_per;
  longint last_lat;
  bit     prev_done;
  exp_t   exp_q[$];
  exp_t   e_acc;
  exp_t   cur;
  longint m_half [NCH];
  longint m_wt [NCH];
  logic [NCH-1:0] exp_tone;
  vec_t   tv [NV];
  int     d0;
  int     a0;
  int     n;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, expv, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Frequency-level reference: Hz x16 table, shift per octave, divide.
  function automatic exp_t model(int ch, int nt, int oc, bit off);
    int     tbl [12];
    exp_t   e;
    int     top;
    int     lo;
    bit     ok;
    longint f;
    tbl = '{56320, 59669, 63217, 66976, 35479, 37589,
            39824, 42192, 44701, 47359, 50175, 53159};
    e.ch  = ch;
    e.wr  = (ch < NCH);
    e.err = 0;
    e.per = 0;
    e.lat = 2;
    e.acc = 0;
    top = (nt == 3) ? 8 : 7;
    lo  = (nt < 3) ? 0 : 1;
    ok  = (nt < 12) && (oc >= lo) && (oc <= top);
    if (ch >= NCH) e.err = 1;
    else if (off) e.err = 0;
    else if (!ok) e.err = 1;
    else begin
      f = longint'(tbl[nt]) >> (top - oc);
      e.per = (longint'(CLK_FREQ) * 8) / f;
      if (e.per > PMAX) e.per = PMAX;
      e.lat = DVD_W + 2;
    end
    return e;
  endfunction

  always @(posedge clock) begin
    if (resetn && req_valid && req_ready) begin
      e_acc = model(int'(req_chan), int'(req_note),
                    int'(req_octave), req_off);
      e_acc.acc = cyc + 1;
      exp_q.push_back(e_acc);
      acc_cnt <= acc_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) m_half[i] = 0;
      prev_done = 1'b0;
      chk("rst_done", done, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_tone", tone_out, 0);
      chk("rst_period", done_period, 0);
      chk("rst_err", done_err, 0);
    end else begin
      if (prev_done) chk("ready_after_done", req_ready, 1);
      if (done) begin
        done_cnt++;
        chk("ready_in_done", req_ready, 0);
        chk("done_expected", exp_q.size() != 0, 1);
        last_err = done_err;
        last_per = done_period;
        last_lat = -1;
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          last_lat = cyc - cur.acc;
          chk("done_err", done_err, cur.err);
          chk("done_period", done_period, cur.per);
          chk("latency", cyc - cur.acc, cur.lat);
          if (cur.wr) begin
            m_half[cur.ch] = cur.per;
            m_wt[cur.ch]   = cyc;
          end
        end
      end
      exp_tone = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_half[i] != 0)
          exp_tone[i] = (((cyc - m_wt[i]) / m_half[i]) % 2) != 0;
      end
      chk("tone_out", tone_out, exp_tone);
      prev_done = done;
    end
  end

  task automatic send(int ch, int nt, int oc, bit off);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    if (!req_ready) bound_fail("send_ready");
    req_chan   = CH_W'(ch);
    req_note   = 4'(nt);
    req_octave = 4'(oc);
    req_off    = off;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 100) bound_fail("wait_idle");
  endtask

  task automatic play(int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_chan   = '0;
    req_note   = '0;
    req_octave = '0;
    req_off    = 1'b0;

    tv[0]  = '{0, 0, 4, 1'b0, 0, 56818, 31};
    tv[1]  = '{1, 0, 0, 1'b0, 0, 909090, 31};
    tv[2]  = '{2, 3, 8, 1'b0, 0, 5972, 31};
    tv[3]  = '{0, 3, 0, 1'b0, 1, 0, 2};
    tv[4]  = '{1, 12, 4, 1'b0, 1, 0, 2};
    tv[5]  = '{0, 0, 9, 1'b0, 1, 0, 2};
    tv[6]  = '{0, 0, 8, 1'b0, 1, 0, 2};
    tv[7]  = '{2, 4, 0, 1'b0, 1, 0, 2};
    tv[8]  = '{2, 4, 8, 1'b0, 1, 0, 2};
    tv[9]  = '{0, 0, 4, 1'b0, 0, 56818, 31};
    tv[10] = '{3, 0, 4, 1'b0, 1, 0, 2};
    tv[11] = '{0, 0, 4, 1'b1, 0, 0, 2};
    tv[12] = '{2, 13, 4, 1'b1, 0, 0, 2};
    tv[13] = '{1, 11, 7, 1'b0, 0, 7524, 31};
    tv[14] = '{0, 4, 1, 1'b0, 0, 722021, 31};
    tv[15] = '{2, 2, 0, 1'b0, 0, 811359, 31};
    tv[16] = '{0, 1, 7, 1'b0, 0, 6703, 31};
    tv[17] = '{3, 13, 9, 1'b1, 1, 0, 2};

    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    play(2);

    for (int k = 0; k < NV; k++) begin
      d0 = done_cnt;
      send(tv[k].ch, tv[k].nt, tv[k].oc, tv[k].off);
      wait_idle();
      chk($sformatf("tbl%0d_done_cnt", k), done_cnt - d0, 1);
      chk($sformatf("tbl%0d_err", k), last_err, tv[k].err);
      chk($sformatf("tbl%0d_period", k), last_per, tv[k].per);
      chk($sformatf("tbl%0d_lat", k), last_lat, tv[k].lat);
    end

    for (int k = 0; k < 40; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 13)),
           int'($urandom_range(0, 9)), $urandom_range(0, 9) == 0);
      wait_idle();
    end

    // Valid held through a whole busy window must be taken once.
    a0         = acc_cnt;
    req_chan   = 2'd0;
    req_note   = 4'd0;
    req_octave = 4'd4;
    req_off    = 1'b0;
    req_valid  = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (!done) bound_fail("hold_done");
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("hold_one_accept", acc_cnt - a0, 1);
    wait_idle();

    // Reset in the middle of a divide abandons the request.
    send(0, 0, 4, 1'b0);
    repeat (10) @(posedge clock);
    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    d0 = done_cnt;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_tone", tone_out, 0);
    play(40);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    send(0, 0, 4, 1'b0);
    wait_idle();
    chk("rst_mid_a4_period", last_per, 56818);
    chk("rst_mid_a4_lat", last_lat, 31);

    send(0, 1, 7, 1'b0);
    wait_idle();
    send(1, 11, 7, 1'b0);
    wait_idle();
    send(2, 3, 8, 1'b0);
    wait_idle();
    play(8000);
    send(3, 5, 4, 1'b0);
    wait_idle();
    chk("oob_chan_err", last_err, 1);
    play(12000);
    send(1, 0, 4, 1'b1);
    wait_idle();
    chk("mute_ch1_period", last_per, 0);
    play(2000);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Multi-channel square-wave tone generator for the audio path.
- Accepts (note, octave) requests over a valid/ready port and computes each channel's half-period from a precision frequency table using an iterative divider.
- Drives one free-running square wave per channel.
- Generalises the fixed integer-Hz, combinational-divide note lookup: 4 fractional frequency bits, parametrised clock, multiple channels, a sequential divide, and mute/error handling.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- CHANNELS, 2, number of independent tone channels (1..8).
- DIV_W, 22, width of each half-period register in clock cycles.
- Derived localparams:
  - CH_W = max(1, clog2(CHANNELS)).
  - DVD_W = clog2(CLK_FREQ*8 + 1), which is 29 at default.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_chan  in  CH_W  target channel.
- req_note  in  4  0=A,1=A#,2=B,3=C,4=C#,5=D,6=D#,7=E,8=F,9=F#,10=G,11=G#.
- req_octave  in  4  octave number.
- req_off  in  1  1 = mute channel (note/octave ignored).
- done  out  1  one-cycle pulse, request completed.
- done_err  out  1  valid with done; request was invalid.
- done_period  out  DIV_W  valid with done; half-period written (0 = silent).
- tone_out  out  CHANNELS  square wave per channel.

Behaviour:
- Reset (async, resetn=0): state IDLE; req_ready=1; done=0; done_err=0; done_period=0; all half-periods, counters and tone_out = 0.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. req_ready=0 from the cycle after acceptance until the cycle after done. Inputs are sampled only at acceptance.
- FSM: IDLE -> LOOKUP -> DIVIDE -> WRITE -> IDLE. Errors and mutes take LOOKUP -> WRITE.
- Table (octave-top frequency in Hz x16, 17 bits):
  - A 56320, A# 59669, B 63217, C 66976, C# 35479, D 37589, D# 39824, E 42192, F 44701, F# 47359, G 50175, G# 53159.
  - Top octave is 8 for C and 7 for all other notes.
- Valid octave ranges: A/A#/B 0..7; C 1..8; C#..G# 1..7.
- LOOKUP (1 cycle): freq_q4 = table >> (top - octave), truncating.
- Error conditions: note >= 12, octave out of range, or req_chan >= CHANNELS.
  - done_err=1, done_period=0.
  - Channel half-period is set to 0, except when req_chan is out of range, in which case no channel is written.
- req_off=1 with a valid channel: half-period=0, done_err=0. req_off takes precedence over an invalid note/octave.
- DIVIDE: restoring divide of CLK_FREQ*8 by freq_q4, one quotient bit per cycle, exactly DVD_W cycles.
  - If the quotient exceeds 2^DIV_W - 1, saturate to all-ones.
- WRITE (1 cycle): update the channel half-period, clear its counter, force its tone_out to 0. done pulses in the cycle after WRITE.
- Latency from acceptance edge to done high:
  - Divide path: DVD_W+2 cycles (31 at default).
  - Mute/error path: 2 cycles.
- Channel (independent, every cycle):
  - If half-period == 0: counter=0, tone_out=0.
  - Otherwise the counter increments. At counter == half-period-1 it wraps to 0 and tone_out toggles.
  - Output frequency = CLK_FREQ / (2*half-period).
- Rewriting a sounding channel restarts its phase. Other channels are unaffected by any request.
- Reset mid-DIVIDE abandons the request: no done, all channels silent, req_ready=1 after reset release.

Test Plan:
- Reset release, then A4 (note 0, octave 4) to channel 0 -> done at +31 cycles; done_period=56818, done_err=0; tone_out[0] toggles every 56818 cycles.
- A0 to channel 1 -> done_period=909090 (freq_q4=440). C8 (note 3, octave 8) -> freq_q4=66976, done_period=5972.
- Invalid requests -> done at +2 cycles, done_err=1, done_period=0, channel 0 silenced:
  - C0 (note 3, octave 0).
  - note 12.
  - octave 9.
- req_chan=2 with CHANNELS=2 -> done_err=1; both channels keep their prior waveforms.
- Mute while channel 0 plays A4 (req_off=1) -> done at +2 cycles, done_period=0, tone_out[0]=0 next cycle. Hold req_valid high through busy -> exactly one acceptance per req_ready window.
- Assert resetn=0 at divide cycle 10 -> no done; all tone_out=0; req_ready=1 after release; a new A4 request completes normally.
